// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and single-outstanding instruction fetch with branch redirect
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] STEP        = 32'(PC_STEP);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;

  logic [31:0] seq_sum;
  logic [31:0] seq_pc_d;
  logic [31:0] br_pc_d;

  // Addresses are word aligned; the low two bits of every candidate are forced to zero.
  assign seq_sum  = pc_q + STEP;
  assign seq_pc_d = {seq_sum[31:2], 2'b00};
  assign br_pc_d  = {br_target[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC_AL;
      tgt_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC_AL;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (br_taken) begin
            pc_q <= br_pc_d;
          end else if (!stall) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end

        FETCH: begin
          if (imem_ack) begin
            req_q <= 1'b0;
            if (br_taken) begin
              pc_q    <= br_pc_d;
              state_q <= IDLE;
            end else begin
              inst_q    <= imem_rdata;
              inst_pc_q <= pc_q;
              valid_q   <= 1'b1;
              pc_q      <= seq_pc_d;
              state_q   <= HOLD;
            end
          end else if (br_taken) begin
            // The bus cannot abandon a request, so it stays up until the stale ack returns.
            tgt_q   <= br_pc_d;
            state_q <= DROP;
          end
        end

        DROP: begin
          if (imem_ack) begin
            req_q   <= 1'b0;
            pc_q    <= br_taken ? br_pc_d : tgt_q;
            state_q <= IDLE;
          end
          if (br_taken) begin
            tgt_q <= br_pc_d;
          end
        end

        HOLD: begin
          if (br_taken) begin
            valid_q <= 1'b0;
            pc_q    <= br_pc_d;
            state_q <= IDLE;
          end else if (inst_ready) begin
            valid_q <= 1'b0;
            if (!stall) begin
              state_q <= FETCH;
              req_q   <= 1'b1;
              addr_q  <= pc_q;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - scoreboard bench for pc_fetch with random memory latency and redirects
module tb_pc_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, inst_ready;
  logic [31:0] br_target;
  logic        imem_req, imem_ack, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_inst, w_inst_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int w_seen   = 0;
  int valid_seen;
  int lat_fixed = 0;
  logic force_ack = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] w_next;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .stall(1'b0), .br_taken(1'b0), .br_target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_addr ^ KEY),
    .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_inst_pc), .inst_ready(1'b1)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or no expectation available", name);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: acknowledges each new request after lat_fixed cycles (random 0-3 when negative).
  int   wait_left = 0;
  logic fresh = 1'b1;
  always begin
    @(posedge clk);
    #1;
    if (!imem_req) begin
      imem_ack   = force_ack;
      imem_rdata = $urandom;
      fresh      = 1'b1;
    end else begin
      if (fresh) begin
        wait_left = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
        fresh     = 1'b0;
      end
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ KEY;
        fresh      = 1'b1;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_left--;
      end
    end
  end

  // Reference model: the next delivered PC is the previous one plus 4, unless a redirect came later.
  logic        p_rst = 1'b0, p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_br = 1'b0;
  logic [31:0] p_addr = '0, p_inst = '0, p_pc = '0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (p_rst) begin
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, inst_valid}, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_w_addr", w_addr, 32'hFFFF_FFFC);
    end else begin
      if (p_req && !p_ack) begin
        chk("req_held", {31'b0, imem_req}, 32'h1);
        chk("addr_held", imem_addr, p_addr);
      end
      if (p_valid && !p_ready && !p_br) begin
        chk("hold_valid", {31'b0, inst_valid}, 32'h1);
        chk("hold_inst", inst, p_inst);
        chk("hold_pc", inst_pc, p_pc);
      end
    end
    if (inst_valid && imem_req) chk("req_in_hold", {31'b0, imem_req}, 32'h0);
    if (imem_addr[1:0] != 2'b00) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);

    if (rst) begin
      exp_q.delete();
      exp_q.push_back(32'h0);
      w_next = 32'hFFFF_FFFC;
    end else begin
      if (inst_valid && inst_ready) begin
        n_deliv++;
        got_pc.push_back(inst_pc);
        if (exp_q.size() == 0) begin
          fail_now("sb_empty");
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", inst_pc, e);
          chk("sb_inst", inst, e ^ KEY);
          exp_q.push_back(e + 32'd4);
        end
      end
      if (br_taken) begin
        exp_q.delete();
        exp_q.push_back({br_target[31:2], 2'b00});
      end
      if (w_valid) begin
        chk("wrap_pc", w_inst_pc, w_next);
        chk("wrap_inst", w_inst, w_next ^ KEY);
        w_next = w_next + 32'd4;
        w_seen++;
      end
    end

    p_rst = rst; p_req = imem_req; p_ack = imem_ack; p_valid = inst_valid;
    p_ready = inst_ready; p_br = br_taken; p_addr = imem_addr; p_inst = inst; p_pc = inst_pc;
  end

  task automatic drain();
    int n = 0;
    stall = 1'b1; inst_ready = 1'b1; br_taken = 1'b0;
    tick();
    while ((imem_req || inst_valid) && n < 30) begin
      tick();
      n++;
    end
    if (imem_req || inst_valid) fail_now("drain_timeout");
  endtask

  task automatic wait_rise(string name);
    int n = 0;
    do begin
      tick();
      n++;
      if (inst_valid) valid_seen++;
    end while (!imem_req && n < 30);
    if (!imem_req) fail_now(name);
  endtask

  task automatic wait_next_req(string name);
    int n = 0;
    while (imem_req && n < 30) begin
      tick();
      n++;
      if (inst_valid) valid_seen++;
    end
    wait_rise(name);
  endtask

  initial begin
    logic [31:0] a0, h_inst, h_pc;
    int n;
    rst = 1'b1; stall = 1'b1; br_taken = 1'b0; br_target = '0; inst_ready = 1'b1;
    repeat (2) tick();
    chk("reset_req", {31'b0, imem_req}, 32'h0);
    chk("reset_valid", {31'b0, inst_valid}, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);

    // Zero-wait streaming from reset
    rst = 1'b0; stall = 1'b0; lat_fixed = 0;
    got_pc.delete();
    n = 0;
    while (got_pc.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    if (got_pc.size() < 3) fail_now("stream_timeout");
    else begin
      chk("stream_pc0", got_pc[0], 32'h0);
      chk("stream_pc1", got_pc[1], 32'h4);
      chk("stream_pc2", got_pc[2], 32'h8);
    end

    // Slow ack with stall toggling: request must stay put
    drain();
    lat_fixed = 3; stall = 1'b0;
    wait_rise("slow_req_timeout");
    a0 = imem_addr;
    for (int i = 0; i < 3; i++) begin
      stall = ~stall;
      tick();
      chk("slow_req", {31'b0, imem_req}, 32'h1);
      chk("slow_addr", imem_addr, a0);
    end
    stall = 1'b0;

    // Redirect during an outstanding fetch at 0x10
    drain();
    br_taken = 1'b1; br_target = 32'h10;
    tick();
    br_taken = 1'b0; lat_fixed = 2; stall = 1'b0;
    wait_rise("drop_req_timeout");
    chk("drop_old_addr", imem_addr, 32'h10);
    br_taken = 1'b1; br_target = 32'h103;
    tick();
    br_taken = 1'b0;
    valid_seen = 0;
    wait_next_req("drop_next_timeout");
    chk("drop_new_addr", imem_addr, 32'h100);
    chk("drop_no_valid", valid_seen, 0);

    // Redirect coincident with ack
    drain();
    lat_fixed = 1; stall = 1'b0;
    wait_rise("same_req_timeout");
    tick();
    br_taken = 1'b1; br_target = 32'h200;
    tick();
    br_taken = 1'b0;
    valid_seen = 0;
    wait_next_req("same_next_timeout");
    chk("same_new_addr", imem_addr, 32'h200);
    chk("same_no_valid", valid_seen, 0);

    // Consumer back-pressure for 5 cycles
    drain();
    lat_fixed = 0; inst_ready = 1'b0; stall = 1'b0;
    n = 0;
    while (!inst_valid && n < 30) begin
      tick();
      n++;
    end
    if (!inst_valid) fail_now("bp_timeout");
    h_inst = inst; h_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'b0, inst_valid}, 32'h1);
      chk("bp_inst", inst, h_inst);
      chk("bp_pc", inst_pc, h_pc);
      chk("bp_req", {31'b0, imem_req}, 32'h0);
    end
    inst_ready = 1'b1;

    // Reset while discarding a redirected fetch, then a stray ack
    drain();
    lat_fixed = 6; stall = 1'b0;
    wait_rise("rstdrop_req_timeout");
    br_taken = 1'b1; br_target = 32'h300;
    tick();
    br_taken = 1'b0; stall = 1'b1;
    chk("rstdrop_in_drop", {31'b0, imem_req}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rstdrop_req", {31'b0, imem_req}, 32'h0);
    chk("rstdrop_addr", imem_addr, 32'h0);
    chk("rstdrop_valid", {31'b0, inst_valid}, 32'h0);
    chk("rstdrop_inst", inst, 32'h0);
    chk("rstdrop_pc", inst_pc, 32'h0);
    rst = 1'b0; force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_ack_valid", {31'b0, inst_valid}, 32'h0);
      chk("stray_ack_req", {31'b0, imem_req}, 32'h0);
    end
    force_ack = 1'b0;

    // Randomized traffic against the scoreboard
    lat_fixed = -1;
    for (int i = 0; i < 4000; i++) begin
      stall      = ($urandom_range(0, 3) == 0);
      br_taken   = ($urandom_range(0, 11) == 0);
      br_target  = $urandom;
      inst_ready = ($urandom_range(0, 9) < 7);
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; br_taken = 1'b0; stall = 1'b1; inst_ready = 1'b1;
    repeat (10) tick();

    if (n_deliv < 200) fail_now("too_few_deliveries");
    if (w_seen < 2) fail_now("wrap_too_few");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
